iq_tap_window_ctrl: RTL and testbench

Sequencer for the I/Q demodulator's 20-tap decimating sample delay line. It counts accepted input samples and issues one shift pulse per DECIM samples. It tracks how many taps hold valid data and presents a valid/ready "window ready" handshake to the downstream correlator once the line is full. It also owns start/stop, flush and overrun reporting for that delay line.

---
 rtl/iq_tap_window_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_iq_tap_window_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_tap_window_ctrl.sv
// ---------------------------------------------------------------------------
// iq_tap_window_ctrl
//
// Sequencer for the I/Q demodulator's decimating tap delay line. It counts
// accepted input samples, issues one shift pulse per DECIM samples, tracks
// how many taps hold valid data, and offers the full window to the
// downstream correlator through a valid/ready handshake. It also owns
// start/stop, flush and overrun reporting for the delay line.
//
// Optional feature (compile-time macro IQ_TAP_PHASE_ADJ_EN):
//   adds phase_adj / phase_adj_ack, a one-sample phase slip used by timing
//   recovery. Without the macro the ports do not exist and every accepted
//   sample advances the phase counter.
//
// Parameters:
//   DEPTH  - taps in the delay line
//   DECIM  - accepted samples per shift (2..8)
//   PH_W   - phase counter width, 2**PH_W >= DECIM
//   FILL_W - fill counter width,  2**FILL_W > DEPTH
//
// Ports:
//   clk           in   main clock
//   reset         in   asynchronous active-low reset
//   enable        in   run request, level-sensitive
//   sync_clr      in   synchronous flush pulse (highest priority after reset)
//   samp_valid    in   new input sample present this cycle
//   win_ready     in   correlator accepts the current window
//   phase_adj     in   one-sample slip request       (IQ_TAP_PHASE_ADJ_EN)
//   phase_adj_ack out  slip consumed, 1-cycle pulse  (IQ_TAP_PHASE_ADJ_EN)
//   shift_en      out  one-cycle shift pulse to the delay line
//   phase_cnt     out  samples accepted since the last shift
//   fill_level    out  valid taps in the delay line, 0..DEPTH
//   win_valid     out  full window available
//   overrun       out  sticky: a window was overwritten before acceptance
//   state         out  FSM state: IDLE=0, FILL=1, RUN=2
// ---------------------------------------------------------------------------
module iq_tap_window_ctrl #(
   parameter int DEPTH  = 20,
   parameter int DECIM  = 5,
   parameter int PH_W   = 3,
   parameter int FILL_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              sync_clr,
   input  logic              samp_valid,
   input  logic              win_ready,
`ifdef IQ_TAP_PHASE_ADJ_EN
   input  logic              phase_adj,
   output logic              phase_adj_ack,
`endif
   output logic              shift_en,
   output logic [PH_W-1:0]   phase_cnt,
   output logic [FILL_W-1:0] fill_level,
   output logic              win_valid,
   output logic              overrun,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

   state_t              state_q, state_d;
   logic                shift_d;
   logic [PH_W-1:0]     phase_d;
   logic [FILL_W-1:0]   fill_d;
   logic                win_valid_d;
   logic                overrun_d;

   // A pending slip makes the next accepted sample leave phase_cnt alone.
   logic                slip_pend;

   // ------------------------------------------------------------------------
   // Optional one-sample phase slip
   // ------------------------------------------------------------------------
`ifdef IQ_TAP_PHASE_ADJ_EN
   logic slip_q, slip_d, ack_d;

   always_comb begin
      slip_d = slip_q;
      ack_d  = 1'b0;
      if (sync_clr || !enable || state_q == IDLE) begin
         // Flush, stop and idle all drop a pending slip.
         slip_d = 1'b0;
      end else begin
         if (samp_valid && slip_q) begin
            slip_d = 1'b0;
            ack_d  = 1'b1;
         end
         // Requests while a slip is already pending are ignored; this also
         // covers a request landing in the cycle the slip is consumed.
         if (phase_adj && !slip_q) begin
            slip_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slip_q        <= 1'b0;
         phase_adj_ack <= 1'b0;
      end else begin
         slip_q        <= slip_d;
         phase_adj_ack <= ack_d;
      end
   end

   assign slip_pend = slip_q;
`else
   assign slip_pend = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      shift_d     = 1'b0;          // shift_en is a single-cycle pulse
      phase_d     = phase_cnt;
      fill_d      = fill_level;
      win_valid_d = win_valid;
      overrun_d   = overrun;

      if (sync_clr) begin
         // Flush wins over everything; a coincident sample is discarded.
         state_d     = enable ? FILL : IDLE;
         phase_d     = '0;
         fill_d      = '0;
         win_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               phase_d     = '0;
               fill_d      = '0;
               win_valid_d = 1'b0;
               if (enable) begin
                  state_d = FILL;
               end
            end

            FILL, RUN: begin
               if (!enable) begin
                  // Stop: the line is abandoned, but overrun stays visible
                  // until a flush or reset.
                  state_d     = IDLE;
                  phase_d     = '0;
                  fill_d      = '0;
                  win_valid_d = 1'b0;
               end else begin
                  // Window handshake. A shift into a full line presents a
                  // new window; if the previous one was still unaccepted it
                  // is overwritten and overrun latches. A handshake in the
                  // same cycle simply lets the new window follow directly.
                  if (shift_en && fill_level == FILL_FULL) begin
                     win_valid_d = 1'b1;
                     if (win_valid && !win_ready) begin
                        overrun_d = 1'b1;
                     end
                  end else if (win_valid && win_ready) begin
                     win_valid_d = 1'b0;
                  end

                  // Sample accounting. fill_level moves on the same edge
                  // that registers shift_en, so it always reflects the taps
                  // the delay line will hold after the pending shift.
                  if (samp_valid && !slip_pend) begin
                     if (phase_cnt == PH_LAST) begin
                        phase_d = '0;
                        shift_d = 1'b1;
                        if (fill_level != FILL_FULL) begin
                           fill_d = fill_level + FILL_W'(1);
                        end
                     end else begin
                        phase_d = phase_cnt + PH_W'(1);
                     end
                  end

                  // RUN is entered on the edge the line becomes full.
                  state_d = (fill_d == FILL_FULL) ? RUN : FILL;
               end
            end

            default: begin
               state_d     = IDLE;
               phase_d     = '0;
               fill_d      = '0;
               win_valid_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_en   <= 1'b0;
         phase_cnt  <= '0;
         fill_level <= '0;
         win_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_en   <= shift_d;
         phase_cnt  <= phase_d;
         fill_level <= fill_d;
         win_valid  <= win_valid_d;
         overrun    <= overrun_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_iq_tap_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iq_tap_window_ctrl
//
// Self-checking bench for iq_tap_window_ctrl. The reference model tracks the
// delay line in terms of "samples that advanced the phase since the last
// start": phase is that count modulo DECIM, the number of shifts is the
// count divided by DECIM, and fill is that number clamped to DEPTH. The
// window flag, overrun and the pending slip are kept as plain booleans.
// Directed segments follow the test plan; a randomized segment follows.
// Define IQ_TAP_PHASE_ADJ_EN for both files to exercise the phase slip.
// ---------------------------------------------------------------------------
module tb_iq_tap_window_ctrl;

   localparam int DEPTH  = 20;
   localparam int DECIM  = 5;
   localparam int PH_W   = 3;
   localparam int FILL_W = 5;
`ifdef IQ_TAP_PHASE_ADJ_EN
   localparam bit HAS_ADJ = 1'b1;
`else
   localparam bit HAS_ADJ = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic              sync_clr;
   logic              samp_valid;
   logic              win_ready;
   logic              phase_adj;
   logic              shift_en;
   logic [PH_W-1:0]   phase_cnt;
   logic [FILL_W-1:0] fill_level;
   logic              win_valid;
   logic              overrun;
   logic [1:0]        state;
`ifdef IQ_TAP_PHASE_ADJ_EN
   logic              phase_adj_ack;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit m_run;        // FILL or RUN
   int m_samples;    // phase-advancing samples since last start
   bit m_shift;
   bit m_wv;
   bit m_ovr;
   bit m_slip;
   bit m_ack;

   always #5 clk = ~clk;

   iq_tap_window_ctrl #(
      .DEPTH (DEPTH),
      .DECIM (DECIM),
      .PH_W  (PH_W),
      .FILL_W(FILL_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .sync_clr     (sync_clr),
      .samp_valid   (samp_valid),
      .win_ready    (win_ready),
`ifdef IQ_TAP_PHASE_ADJ_EN
      .phase_adj    (phase_adj),
      .phase_adj_ack(phase_adj_ack),
`endif
      .shift_en     (shift_en),
      .phase_cnt    (phase_cnt),
      .fill_level   (fill_level),
      .win_valid    (win_valid),
      .overrun      (overrun),
      .state        (state)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int m_fill();
      int f;
      f = m_samples / DECIM;
      return (f > DEPTH) ? DEPTH : f;
   endfunction

   function automatic int m_state();
      if (!m_run) return 0;
      return (m_fill() == DEPTH) ? 2 : 1;
   endfunction

   task automatic model_reset();
      m_run = 0; m_samples = 0; m_shift = 0; m_wv = 0; m_ovr = 0; m_slip = 0; m_ack = 0;
   endtask

   // One clock edge of the reference model, from the inputs seen at that edge.
   task automatic model_edge(input bit en, input bit clr, input bit sv, input bit rdy, input bit adj);
      bit old_shift, old_slip, old_wv;
      int old_fill;
      old_shift = m_shift;
      old_slip  = m_slip;
      old_wv    = m_wv;
      old_fill  = m_fill();
      m_shift   = 0;
      m_ack     = 0;
      if (clr) begin
         m_run = en; m_samples = 0; m_wv = 0; m_ovr = 0; m_slip = 0;
      end else if (!m_run) begin
         m_run = en;
      end else if (!en) begin
         m_run = 0; m_samples = 0; m_wv = 0; m_slip = 0;
      end else begin
         if (old_shift && old_fill == DEPTH) begin
            if (old_wv && !rdy) m_ovr = 1;
            m_wv = 1;
         end else if (old_wv && rdy) begin
            m_wv = 0;
         end
         if (sv) begin
            if (old_slip) begin
               m_slip = 0;
               m_ack  = 1;
            end else begin
               m_samples++;
               if (m_samples % DECIM == 0) m_shift = 1;
            end
         end
         if (adj && !old_slip) m_slip = 1;
      end
   endtask

   task automatic check_outputs();
      check("shift_en",   32'(shift_en),   32'(m_shift));
      check("phase_cnt",  32'(phase_cnt),  m_samples % DECIM);
      check("fill_level", 32'(fill_level), m_fill());
      check("win_valid",  32'(win_valid),  32'(m_wv));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("state",      32'(state),      m_state());
`ifdef IQ_TAP_PHASE_ADJ_EN
      check("phase_adj_ack", 32'(phase_adj_ack), 32'(m_ack));
`endif
   endtask

   // Called at a negedge: drive inputs, step the model at the posedge, check
   // at the following negedge.
   task automatic cycle(input bit en, input bit clr, input bit sv, input bit rdy, input bit adj);
      enable     = en;
      sync_clr   = clr;
      samp_valid = sv;
      win_ready  = rdy;
      phase_adj  = adj;
      @(posedge clk);
      model_edge(en, clr, sv, rdy, HAS_ADJ && adj);
      @(negedge clk);
      check_outputs();
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("rst shift_en",   32'(shift_en),   0);
      check("rst phase_cnt",  32'(phase_cnt),  0);
      check("rst fill_level", 32'(fill_level), 0);
      check("rst win_valid",  32'(win_valid),  0);
      check("rst overrun",    32'(overrun),    0);
      check("rst state",      32'(state),      0);
      model_reset();
      #1 reset = 1'b1;
   endtask

   initial begin
      reset      = 1'b0;
      enable     = 1'b0;
      sync_clr   = 1'b0;
      samp_valid = 1'b0;
      win_ready  = 1'b0;
      phase_adj  = 1'b0;
      model_reset();
      @(negedge clk);
      check_outputs();
      reset = 1'b1;

      // Idle ignores samples.
      repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Basic fill: continuous samples, correlator always ready.
      repeat (130) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // Gapped input, one sample every third cycle, after a flush.
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 330; i++) cycle(1'b1, 1'b0, (i % 3) == 0, 1'b1, 1'b0);

      // Backpressure in RUN: overrun on the second shift, then a handshake.
      repeat (12) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush mid-fill with fill_level=7, phase_cnt=3; coincident sample dropped.
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (7 * DECIM + 3) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // Stop with phase_cnt=4 and a final sample: no shift is issued.
      repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Async reset with a window pending.
      repeat (DEPTH * DECIM + 3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      async_reset();
      repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // Phase slip during continuous samples (no effect without the feature).
      repeat (7) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // Randomized traffic in segments with different sample/ready densities.
      for (int seg = 0; seg < 8; seg++) begin
         int sv_pct, rdy_pct;
         sv_pct  = 30 + 10 * seg;
         rdy_pct = (seg % 2 == 0) ? 90 : 40;
         for (int i = 0; i < 500; i++) begin
            bit en, clr, sv, rdy, adj;
            en  = ($urandom_range(0, 299) != 0);
            clr = ($urandom_range(0, 249) == 0);
            sv  = ($urandom_range(0, 99) < sv_pct);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            adj = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 999) == 0) async_reset();
            cycle(en, clr, sv, rdy, adj);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
